// File: rtl/microstep_sequencer.sv
// Microstep sequencer: steps through microinstruction slots on the falling clock edge.
// Supports a protected fetch window, early end-of-instruction, halt, single-instruction parking and a retire counter.
module microstep_sequencer #(
   parameter  int INSTRUCTION_STEPS = 8,
   parameter  int FETCH_STEPS       = 2,
   parameter  int RETIRE_WIDTH      = 16,
   localparam int STEP_WIDTH        = (INSTRUCTION_STEPS > 2) ? $clog2(INSTRUCTION_STEPS) : 1
) (
   input  logic                         mclk,
   input  logic                         i_rst_n,
   input  logic                         mclk_en,
   input  logic                         i_halt,
   input  logic                         i_adv,
   input  logic                         i_single_mode,
   input  logic                         i_step_req,
   output logic [STEP_WIDTH-1:0]        o_step,
   output logic [INSTRUCTION_STEPS-1:0] o_step_onehot,
   output logic                         o_fetch,
   output logic                         o_instr_done,
   output logic                         o_halted,
   output logic                         o_waiting,
   output logic [RETIRE_WIDTH-1:0]      o_retired
);

   typedef enum logic [1:0] {RUN, PARK, HALTED} state_t;

   localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

   state_t                state;
   logic [STEP_WIDTH-1:0] step;
   logic                  fetch;
   logic                  retire;

   generate
      if (FETCH_STEPS == 0) begin : g_no_fetch
         assign fetch = 1'b0;
      end else begin : g_fetch
         localparam logic [STEP_WIDTH-1:0] FETCH_LIM = STEP_WIDTH'(FETCH_STEPS);
         assign fetch = (step < FETCH_LIM);
      end
   endgenerate

   // Early end-of-instruction is only honoured once the fetch window has passed.
   assign retire = (step == LAST_STEP) | (i_adv & ~fetch);

   always_ff @(negedge mclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= RUN;
         step         <= '0;
         o_instr_done <= 1'b0;
         o_retired    <= '0;
      end else if (mclk_en) begin
         o_instr_done <= 1'b0;
         if (i_halt) begin
            state <= HALTED;
         end else begin
            case (state)
               HALTED: state <= RUN;
               PARK: begin
                  if (i_step_req | ~i_single_mode) state <= RUN;
               end
               default: begin
                  if (retire) begin
                     step         <= '0;
                     o_retired    <= o_retired + RETIRE_WIDTH'(1);
                     o_instr_done <= 1'b1;
                     state        <= i_single_mode ? PARK : RUN;
                  end else begin
                     step <= step + STEP_WIDTH'(1);
                  end
               end
            endcase
         end
      end
   end

   assign o_step        = step;
   assign o_step_onehot = INSTRUCTION_STEPS'(1) << step;
   assign o_fetch       = fetch;
   assign o_halted      = (state == HALTED);
   assign o_waiting     = (state == PARK);

endmodule

// File: tb/tb_microstep_sequencer.sv
// Bench for microstep_sequencer (6 steps, 2-step fetch window, 4-bit retire counter):
// directed scenarios followed by random stimulus, checked against a queue-fed reference model.
module tb_microstep_sequencer;

   localparam int NSTEPS = 6;
   localparam int NFETCH = 2;
   localparam int RW     = 4;

   logic        mclk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        mclk_en = 1'b1;
   logic        i_halt = 1'b0;
   logic        i_adv = 1'b0;
   logic        i_single_mode = 1'b0;
   logic        i_step_req = 1'b0;
   logic [2:0]  o_step;
   logic [5:0]  o_step_onehot;
   logic        o_fetch;
   logic        o_instr_done;
   logic        o_halted;
   logic        o_waiting;
   logic [3:0]  o_retired;

   microstep_sequencer #(
      .INSTRUCTION_STEPS(NSTEPS),
      .FETCH_STEPS(NFETCH),
      .RETIRE_WIDTH(RW)
   ) dut (
      .mclk(mclk), .i_rst_n(i_rst_n), .mclk_en(mclk_en), .i_halt(i_halt), .i_adv(i_adv),
      .i_single_mode(i_single_mode), .i_step_req(i_step_req), .o_step(o_step),
      .o_step_onehot(o_step_onehot), .o_fetch(o_fetch), .o_instr_done(o_instr_done),
      .o_halted(o_halted), .o_waiting(o_waiting), .o_retired(o_retired)
   );

   always #5 mclk = ~mclk;

   typedef struct {
      int step;
      int onehot;
      int fetch;
      int done;
      int halted;
      int waiting;
      int retired;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: mode 0 = running, 1 = parked, 2 = halted.
   int m_step = 0, m_mode = 0, m_done = 0, m_retired = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_edge(input bit halt, input bit adv, input bit single, input bit req);
      bit ends;
      m_done = 0;
      if (halt) begin
         m_mode = 2;
      end else if (m_mode == 2) begin
         m_mode = 0;
      end else if (m_mode == 1) begin
         if (req || !single) m_mode = 0;
      end else begin
         ends = (m_step == NSTEPS - 1) || (adv && m_step >= NFETCH);
         if (ends) begin
            m_step    = 0;
            m_retired = (m_retired + 1) % (1 << RW);
            m_done    = 1;
            m_mode    = single ? 1 : 0;
         end else begin
            m_step = m_step + 1;
         end
      end
   endtask

   // rmode: 0 none, 1 short reset pulse before the edge, 2 reset held across the edge
   task automatic cycle(input bit en, input bit halt, input bit adv, input bit single,
                        input bit req, input int rmode);
      exp_t e;
      @(posedge mclk);
      #1;
      mclk_en = en; i_halt = halt; i_adv = adv; i_single_mode = single; i_step_req = req;
      i_rst_n = (rmode == 2) ? 1'b0 : 1'b1;
      if (rmode != 0) begin
         m_step = 0; m_mode = 0; m_done = 0; m_retired = 0;
      end
      if (rmode == 1) begin
         i_rst_n = 1'b0;
         #1;
         i_rst_n = 1'b1;
      end
      if (rmode != 2 && en) model_edge(halt, adv, single, req);
      e.step    = m_step;
      e.onehot  = 1 << m_step;
      e.fetch   = (m_step < NFETCH) ? 1 : 0;
      e.done    = m_done;
      e.halted  = (m_mode == 2) ? 1 : 0;
      e.waiting = (m_mode == 1) ? 1 : 0;
      e.retired = m_retired;
      sb.push_back(e);
   endtask

   // Monitor: outputs settle after the falling edge and are sampled on the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge mclk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("step",    int'(o_step),        e.step);
            chk("onehot",  int'(o_step_onehot), e.onehot);
            chk("fetch",   int'(o_fetch),       e.fetch);
            chk("done",    int'(o_instr_done),  e.done);
            chk("halted",  int'(o_halted),      e.halted);
            chk("waiting", int'(o_waiting),     e.waiting);
            chk("retired", int'(o_retired),     e.retired);
         end
      end
   end

   initial begin
      bit single;
      int rm;
      cycle(1, 0, 0, 0, 0, 2);
      cycle(1, 0, 0, 0, 0, 2);
      for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0, 0);        // free run across a retire
      for (int i = 0; i < 8; i++)  cycle(1, 0, 1, 0, 0, 0);        // early end, fetch protected
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++)  cycle(1, 1, 0, 0, 0, 0);        // halt hold
      for (int i = 0; i < 3; i++)  cycle(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) cycle(1, 0, 0, 1, 0, 0);        // single mode parks
      cycle(1, 0, 0, 1, 1, 0);
      for (int i = 0; i < 8; i++)  cycle(1, 0, 0, 1, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++)  cycle(0, 0, 1, 0, 0, 0);        // clock enable low
      for (int i = 0; i < 3; i++)  cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 1);                                     // async reset mid-instruction
      for (int i = 0; i < 110; i++) cycle(1, 0, 0, 0, 0, 0);       // retire counter wraps
      single = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) single = ~single;
         rm = ($urandom_range(0, 199) == 0) ? 1 : (($urandom_range(0, 299) == 0) ? 2 : 0);
         cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
               single, $urandom_range(0, 3) == 0, rm);
      end
      repeat (3) @(posedge mclk);
      #2;
      chk("drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
